vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates raster timing for the VGA path: horizontal/vertical pixel counters, sync pulses, active-video flag and frame-start pulse.
- Sits directly upstream of the background/object draw stages; its pixelX/pixelY drive them.
- Also provides sync/blank copies delayed to match the registered latency of the downstream draw and mux stages.
- Default timing is 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pixel-tick delay on the *_d outputs; legal range 0..3

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixelEn  in  1  pixel-rate enable; counters advance only on clk edges where pixelEn=1
- pixelX  out  11  horizontal count, 0..H_TOTAL-1
- pixelY  out  11  vertical count, 0..V_TOTAL-1
- displayEn  out  1  1 when pixelX<H_ACTIVE and pixelY<V_ACTIVE
- hSyncN  out  1  active-low horizontal sync, aligned with pixelX
- vSyncN  out  1  active-low vertical sync, aligned with pixelY
- hSyncN_d  out  1  hSyncN delayed SYNC_DELAY pixel ticks
- vSyncN_d  out  1  vSyncN delayed SYNC_DELAY pixel ticks
- displayEn_d  out  1  displayEn delayed SYNC_DELAY pixel ticks
- startOfFrame  out  1  one-clk pulse when (0,0) is presented
- frameCount  out  8  frame counter, wraps 255->0

Behaviour:
Interface:
- One clock, clk.
- Reset port is reset: asynchronous, active-high.

Timing arithmetic:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Reset:
- All outputs take reset values immediately on reset assertion, with no clock required.
- pixelX=H_TOTAL-1 (799), pixelY=V_TOTAL-1 (524), displayEn=0, hSyncN=1, vSyncN=1, startOfFrame=0, frameCount=0.
- Delay line is filled with the inactive value (1,1,0).
- Consequence: the first pixelEn tick after reset release presents (0,0).

Counter update (clk edge with pixelEn=1):
- pixelX==H_TOTAL-1: pixelX<=0 and pixelY advances; otherwise pixelX<=pixelX+1.
- pixelY advances to pixelY+1, or wraps to 0 from V_TOTAL-1.
- With pixelEn=0, all counters and aligned outputs hold.

Decoded outputs:
- displayEn, hSyncN and vSyncN are registered and decoded from the next count values.
- They therefore change on the same edge as pixelX/pixelY, with zero skew relative to the counters.
- hSyncN=0 iff H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC (656..751).
- vSyncN=0 iff V_ACTIVE+V_FP <= pixelY < V_ACTIVE+V_FP+V_SYNC (490..491), for the full line width.

startOfFrame and frameCount:
- startOfFrame=1 for exactly one clk cycle: the cycle following the edge that loads (0,0).
- It is low at all other times, including further held cycles of (0,0) while pixelEn=0.
- frameCount increments on that same edge, so the first frame after reset reads 1.

Delayed outputs:
- *_d outputs come from a shift register of depth SYNC_DELAY that advances only on pixelEn.
- SYNC_DELAY=0: *_d equal their undelayed counterparts combinationally.

Boundary conditions:
- Simultaneous h-wrap and v-wrap at (799,524): both wrap on the same edge; startOfFrame fires.
- Reset asserted mid-frame forces the reset state at once; counting restarts from (0,0) on the first pixelEn after release.
- Reset has priority over pixelEn.

Test Plan:
1. Reset, release, pixelEn=1 constantly -> first edge gives pixelX=0, pixelY=0, displayEn=1, startOfFrame=1 for one clk, frameCount=1.
2. Monitor one line -> displayEn high for pixelX 0..639 only; hSyncN low for exactly 96 ticks, pixelX 656..751; line period 800 ticks.
3. Full frame -> vSyncN low only on lines 490..491 (1600 ticks); wrap (799,524)->(0,0); frame period 420000 ticks; startOfFrame once per frame.
4. pixelEn alternating 1/0 -> counters hold on disabled cycles; startOfFrame still exactly one clk wide; frame period 840000 clk.
5. SYNC_DELAY=1 -> hSyncN_d falls one pixel tick after hSyncN (at pixelX=657). SYNC_DELAY=0 -> *_d identical to undelayed outputs.
6. Assert reset at (300,100) with no clock edge -> outputs immediately 799/524, hSyncN=vSyncN=1, frameCount=0. Run 256 frames -> frameCount wraps 255->0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and the downstream draw/mux stages.
// The generator is the master; pixelEn is the only signal flowing back into it.
interface vga_timing_gen_if;
  logic        pixelEn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        displayEn;
  logic        hSyncN;
  logic        vSyncN;
  logic        hSyncN_d;
  logic        vSyncN_d;
  logic        displayEn_d;
  logic        startOfFrame;
  logic [7:0]  frameCount;

  modport master (
    input  pixelEn,
    output pixelX, pixelY, displayEn, hSyncN, vSyncN,
           hSyncN_d, vSyncN_d, displayEn_d, startOfFrame, frameCount
  );

  modport slave (
    output pixelEn,
    input  pixelX, pixelY, displayEn, hSyncN, vSyncN,
           hSyncN_d, vSyncN_d, displayEn_d, startOfFrame, frameCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, registered sync/blank decode, frame pulse/counter,
// and a pixel-tick delay line that aligns sync/blank with the downstream draw pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic h_sync_n;
    logic v_sync_n;
    logic display_en;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{h_sync_n: 1'b1, v_sync_n: 1'b1, display_en: 1'b0};

  logic [10:0] pixel_x, pixel_y;
  logic [10:0] x_next, y_next;
  sync_t       sync_q, sync_next, sync_d;
  logic        sof_q;
  logic [7:0]  frame_q;

  // Decode from the next count so sync/blank land on the same edge as the counters.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    x_next = pixel_x + 11'd1;
    y_next = pixel_y;
    if (pixel_x == H_LAST) begin
      x_next = '0;
      y_next = (pixel_y == V_LAST) ? 11'd0 : pixel_y + 11'd1;
    end
    sync_next.h_sync_n   = !((x_next >= HS_START) && (x_next < HS_END));
    sync_next.v_sync_n   = !((y_next >= VS_START) && (y_next < VS_END));
    sync_next.display_en = (x_next < H_ACT) && (y_next < V_ACT);
  end

  // Reset parks the raster on the last pixel so the first enabled tick presents (0,0).
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (reset) begin
      pixel_x <= H_LAST;
      pixel_y <= V_LAST;
      sync_q  <= SYNC_IDLE;
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      sof_q <= 1'b0;
      if (vga.pixelEn) begin
        pixel_x <= x_next;
        pixel_y <= y_next;
        sync_q  <= sync_next;
        if ((x_next == 11'd0) && (y_next == 11'd0)) begin
          sof_q   <= 1'b1;
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign sync_d = sync_q;
    end else begin : g_delay
      sync_t dly_q [SYNC_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        // NOTE: this small delay array is reset, unlike a RAM, because its contents drive sync pins that must be idle straight out of reset.
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= SYNC_IDLE;
        end else if (vga.pixelEn) begin
          dly_q[0] <= sync_q;
          for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign sync_d = dly_q[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.pixelX       = pixel_x;
  assign vga.pixelY       = pixel_y;
  assign vga.displayEn    = sync_q.display_en;
  assign vga.hSyncN       = sync_q.h_sync_n;
  assign vga.vSyncN       = sync_q.v_sync_n;
  assign vga.hSyncN_d     = sync_d.h_sync_n;
  assign vga.vSyncN_d     = sync_d.v_sync_n;
  assign vga.displayEn_d  = sync_d.display_en;
  assign vga.startOfFrame = sof_q;
  assign vga.frameCount   = frame_q;

endmodule
